ds_hazard_ctrl: RTL and testbench

//  Interlock/forwarding scheduler for the ID stage of the 5-stage pipeline. Shadows each in-flight

---
 rtl/ds_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_ds_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ds_hazard_ctrl.sv
// ID-stage interlock and forwarding scheduler: shadows ES/MS/WS destinations and resolves
// per-operand stall and forward-source selection, plus a saturating stall-cycle counter.
module ds_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ds_valid,
  input  logic             ds_rf_we,
  input  logic             ds_load_op,
  input  logic [RA_W-1:0]  ds_waddr,
  input  logic             ds_use_rs,
  input  logic             ds_use_rt,
  input  logic [RA_W-1:0]  ds_rs_addr,
  input  logic [RA_W-1:0]  ds_rt_addr,
  input  logic             es_allowin,
  input  logic             es_ready_go,
  input  logic             ms_allowin,
  input  logic             ms_ready_go,
  input  logic             ws_allowin,
  output logic             ds_ready_go,
  output logic [1:0]       rs_fwd_sel,
  output logic [1:0]       rt_fwd_sel,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_cnt_clr
);

  typedef struct packed {
    logic            v;
    logic            we;
    logic            ld;
    logic [RA_W-1:0] waddr;
  } slot_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] sel;
  } res_t;

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_ES = 2'd1;
  localparam logic [1:0] SEL_MS = 2'd2;
  localparam logic [1:0] SEL_WS = 2'd3;

  slot_t es_slot, ms_slot, ws_slot;
  res_t  rs_res, rt_res;
  logic  stall;

  function automatic logic slot_hit(input slot_t s, input logic use_op,
                                    input logic [RA_W-1:0] addr);
    return use_op && s.v && s.we && (s.waddr == addr) && (addr != '0);
  endfunction

  // Youngest producer wins: an ES match hides any older MS/WS match of the same register.
  function automatic res_t resolve(input slot_t es, input slot_t ms, input slot_t ws,
                                   input logic use_op, input logic [RA_W-1:0] addr);
    res_t r;
    r = '{stall: 1'b0, sel: SEL_RF};
    if (slot_hit(es, use_op, addr)) begin
      if (es.ld) r.stall = 1'b1;
      else       r.sel   = SEL_ES;
    end else if (slot_hit(ms, use_op, addr)) begin
      if (ms.ld) r.stall = 1'b1;
      else       r.sel   = SEL_MS;
    end else if (slot_hit(ws, use_op, addr)) begin
      r.sel = SEL_WS;
    end
    return r;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rs_res      = resolve(es_slot, ms_slot, ws_slot, ds_use_rs, ds_rs_addr);
    rt_res      = resolve(es_slot, ms_slot, ws_slot, ds_use_rt, ds_rt_addr);
    stall       = ds_valid && (rs_res.stall || rt_res.stall);
    ds_ready_go = !stall;
    rs_fwd_sel  = SEL_RF;
    rt_fwd_sel  = SEL_RF;
    if (!stall) begin
      rs_fwd_sel = rs_res.sel;
      rt_fwd_sel = rt_res.sel;
    end
  end

  // NOTE: state uses non-blocking assignments so all three slots shift on the same edge from
  // pre-edge values; the later flush assignment to .v overrides the handshake loads.
  // NOTE: the slots are plain registers, so the whole slot is reset, not just the valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_slot <= '0;
      ms_slot <= '0;
      ws_slot <= '0;
    end else begin
      if (es_allowin)
        es_slot <= '{v: ds_valid && ds_ready_go, we: ds_rf_we, ld: ds_load_op, waddr: ds_waddr};
      if (ms_allowin)
        ms_slot <= '{v: es_slot.v && es_ready_go, we: es_slot.we, ld: es_slot.ld,
                     waddr: es_slot.waddr};
      if (ws_allowin)
        ws_slot <= '{v: ms_slot.v && ms_ready_go, we: ms_slot.we, ld: ms_slot.ld,
                     waddr: ms_slot.waddr};
      if (flush) begin
        es_slot.v <= 1'b0;
        ms_slot.v <= 1'b0;
        ws_slot.v <= 1'b0;
      end
    end
  end

  // Clear beats increment; the count sticks at all-ones instead of wrapping. Flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall_cnt_clr)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ds_hazard_ctrl.sv
// Self-checking bench for ds_hazard_ctrl: directed scenarios then random traffic, all compared
// against a slot-array reference model built from the scheduling rules.
module tb_ds_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, flush, stall_cnt_clr;
  logic             ds_valid, ds_rf_we, ds_load_op, ds_use_rs, ds_use_rt;
  logic [RA_W-1:0]  ds_waddr, ds_rs_addr, ds_rt_addr;
  logic             es_allowin, es_ready_go, ms_allowin, ms_ready_go, ws_allowin;
  logic             ds_ready_go;
  logic [1:0]       rs_fwd_sel, rt_fwd_sel;
  logic [CNT_W-1:0] stall_cnt;

  ds_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ds_valid(ds_valid), .ds_rf_we(ds_rf_we), .ds_load_op(ds_load_op), .ds_waddr(ds_waddr),
    .ds_use_rs(ds_use_rs), .ds_use_rt(ds_use_rt), .ds_rs_addr(ds_rs_addr), .ds_rt_addr(ds_rt_addr),
    .es_allowin(es_allowin), .es_ready_go(es_ready_go), .ms_allowin(ms_allowin),
    .ms_ready_go(ms_ready_go), .ws_allowin(ws_allowin),
    .ds_ready_go(ds_ready_go), .rs_fwd_sel(rs_fwd_sel), .rt_fwd_sel(rt_fwd_sel),
    .stall_cnt(stall_cnt), .stall_cnt_clr(stall_cnt_clr)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 = ES (youngest), 1 = MS, 2 = WS.
  typedef struct {
    bit v;
    bit we;
    bit ld;
    int a;
  } mslot_t;

  mslot_t m[3];
  int     cnt;
  bit     exp_stall;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_resolve(input bit use_op, input int addr,
                                        output bit st, output int sel);
    bit found = 0;
    st  = 0;
    sel = 0;
    if (use_op && addr != 0) begin
      for (int i = 0; i < 3; i++) begin
        if (!found && m[i].v && m[i].we && m[i].a == addr) begin
          found = 1;
          if (i < 2 && m[i].ld) st  = 1;
          else                  sel = i + 1;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m[i] = '{v: 0, we: 0, ld: 0, a: 0};
    cnt = 0;
  endfunction

  task automatic set_id(input bit v, input bit we, input bit ld, input int wa,
                        input bit urs, input int rs, input bit urt, input int rt);
    ds_valid   = v;
    ds_rf_we   = we;
    ds_load_op = ld;
    ds_waddr   = RA_W'(wa);
    ds_use_rs  = urs;
    ds_rs_addr = RA_W'(rs);
    ds_use_rt  = urt;
    ds_rt_addr = RA_W'(rt);
  endtask

  task automatic set_hs(input bit ea, input bit er, input bit ma, input bit mr, input bit wa);
    es_allowin  = ea;
    es_ready_go = er;
    ms_allowin  = ma;
    ms_ready_go = mr;
    ws_allowin  = wa;
  endtask

  // Called at a falling edge with inputs applied; checks the combinational outputs.
  task automatic eval();
    bit s_rs, s_rt;
    int sel_rs, sel_rt;
    #1;
    model_resolve(ds_use_rs, int'(ds_rs_addr), s_rs, sel_rs);
    model_resolve(ds_use_rt, int'(ds_rt_addr), s_rt, sel_rt);
    exp_stall = ds_valid && (s_rs || s_rt);
    check("ready_go", 32'(ds_ready_go), 32'(!exp_stall));
    check("rs_sel", 32'(rs_fwd_sel), exp_stall ? 32'd0 : 32'(sel_rs));
    check("rt_sel", 32'(rt_fwd_sel), exp_stall ? 32'd0 : 32'(sel_rt));
  endtask

  // Advances the model across one rising edge, checks the counter, returns at the next falling edge.
  task automatic tick();
    mslot_t n[3];
    n[0] = es_allowin ? '{v: ds_valid && !exp_stall, we: ds_rf_we, ld: ds_load_op,
                          a: int'(ds_waddr)} : m[0];
    n[1] = ms_allowin ? '{v: m[0].v && es_ready_go, we: m[0].we, ld: m[0].ld, a: m[0].a} : m[1];
    n[2] = ws_allowin ? '{v: m[1].v && ms_ready_go, we: m[1].we, ld: m[1].ld, a: m[1].a} : m[2];
    if (flush) for (int i = 0; i < 3; i++) n[i].v = 0;
    if (stall_cnt_clr)                  cnt = 0;
    else if (exp_stall && cnt < CMAX)   cnt++;
    @(posedge clk);
    m = n;
    #1;
    check("stall_cnt", 32'(stall_cnt), 32'(cnt));
    @(negedge clk);
  endtask

  task automatic cycle();
    eval();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    stall_cnt_clr = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_hs(1, 1, 1, 1, 1);
    model_reset();
    #3;
    check("rst_go", 32'(ds_ready_go), 32'd1);
    check("rst_rs_sel", 32'(rs_fwd_sel), 32'd0);
    check("rst_rt_sel", 32'(rt_fwd_sel), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: ALU result forwarded from ES, then MS, then WS, then RF.
    set_id(1, 1, 0, 3, 0, 0, 0, 0);
    cycle();
    set_id(1, 0, 0, 0, 1, 3, 0, 0);
    eval(); check("t1_es", 32'(rs_fwd_sel), 32'd1); check("t1_go", 32'(ds_ready_go), 32'd1); tick();
    eval(); check("t1_ms", 32'(rs_fwd_sel), 32'd2); tick();
    eval(); check("t1_ws", 32'(rs_fwd_sel), 32'd3); tick();
    eval(); check("t1_rf", 32'(rs_fwd_sel), 32'd0); tick();

    // 2: load-use stalls for ES and MS, forwards from WS.
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    stall_cnt_clr = 1'b1;
    cycle();
    stall_cnt_clr = 1'b0;
    set_id(1, 1, 1, 5, 0, 0, 0, 0);
    cycle();
    set_id(1, 1, 0, 6, 0, 0, 1, 5);
    eval(); check("t2_go_es", 32'(ds_ready_go), 32'd0); tick();
    eval(); check("t2_go_ms", 32'(ds_ready_go), 32'd0); tick();
    eval(); check("t2_go_ws", 32'(ds_ready_go), 32'd1); check("t2_rt_ws", 32'(rt_fwd_sel), 32'd3);
    tick();
    check("t2_cnt", 32'(stall_cnt), 32'd2);

    // 3: younger ALU write in ES shadows an older load in MS.
    set_id(1, 1, 1, 4, 0, 0, 0, 0);
    cycle();
    set_id(1, 1, 0, 4, 0, 0, 0, 0);
    cycle();
    set_id(1, 0, 0, 0, 1, 4, 0, 0);
    eval(); check("t3_sel", 32'(rs_fwd_sel), 32'd1); check("t3_go", 32'(ds_ready_go), 32'd1); tick();

    // 4: $zero never forwarded; unused operand ignores a match.
    set_id(1, 1, 0, 0, 0, 0, 0, 0);
    cycle();
    set_id(1, 0, 0, 0, 1, 0, 0, 0);
    eval(); check("t4_r0", 32'(rs_fwd_sel), 32'd0); check("t4_go", 32'(ds_ready_go), 32'd1); tick();
    set_id(1, 1, 0, 7, 0, 0, 0, 0);
    cycle();
    set_id(1, 0, 0, 0, 0, 7, 0, 7);
    eval(); check("t4_unused_rs", 32'(rs_fwd_sel), 32'd0);
    check("t4_unused_rt", 32'(rt_fwd_sel), 32'd0); tick();

    // 5: MS back-pressure holds a load in ES; flush releases the stall.
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    stall_cnt_clr = 1'b1;
    cycle();
    stall_cnt_clr = 1'b0;
    set_id(1, 1, 1, 2, 0, 0, 0, 0);
    cycle();
    set_id(1, 0, 0, 0, 1, 2, 0, 0);
    set_hs(0, 1, 0, 1, 1);
    repeat (3) begin
      eval(); check("t5_hold", 32'(ds_ready_go), 32'd0); tick();
    end
    check("t5_cnt", 32'(stall_cnt), 32'd3);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    eval(); check("t5_flush_go", 32'(ds_ready_go), 32'd1);
    check("t5_flush_sel", 32'(rs_fwd_sel), 32'd0); tick();
    set_hs(1, 1, 1, 1, 1);

    // 6: asynchronous reset in the middle of a stall, then counter saturation.
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    stall_cnt_clr = 1'b1;
    cycle();
    stall_cnt_clr = 1'b0;
    set_id(1, 1, 1, 2, 0, 0, 0, 0);
    cycle();
    set_id(1, 0, 0, 0, 1, 2, 1, 2);
    set_hs(0, 1, 0, 1, 1);
    repeat (9) cycle();
    check("t6_cnt9", 32'(stall_cnt), 32'd9);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("t6_rst_go", 32'(ds_ready_go), 32'd1);
    check("t6_rst_rs", 32'(rs_fwd_sel), 32'd0);
    check("t6_rst_rt", 32'(rt_fwd_sel), 32'd0);
    check("t6_rst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    set_id(1, 1, 1, 2, 0, 0, 0, 0);
    set_hs(1, 1, 1, 1, 1);
    cycle();
    set_id(1, 0, 0, 0, 1, 2, 0, 0);
    set_hs(0, 1, 0, 1, 1);
    repeat (CMAX + 9) cycle();
    check("t6_sat", 32'(stall_cnt), 32'(CMAX));
    cycle();
    check("t6_sat_hold", 32'(stall_cnt), 32'(CMAX));
    flush = 1'b1;
    set_hs(1, 1, 1, 1, 1);
    cycle();
    flush = 1'b0;

    // Random traffic on a small register range to provoke frequent hazards.
    for (int k = 0; k < 600; k++) begin
      set_id($urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3));
      set_hs($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      stall_cnt_clr = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
